// File: rtl/simple_fpga_cvs_pkg.sv
// Shared board-level constants for the simple FPGA control path.
// CLK_10MHZ_HZ              : system clock frequency delivered by the MMCM
// DEBOUNCE_TICK_DIV_DEFAULT : clk cycles per 1 ms debounce tick at that frequency
`timescale 1ns/1ps
package simple_fpga_cvs_pkg;

  localparam int CLK_10MHZ_HZ = 10_000_000;

  function automatic int cycles_per_ms(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  localparam int DEBOUNCE_TICK_DIV_DEFAULT = cycles_per_ms(CLK_10MHZ_HZ);

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, tick-qualified agreement counter,
// debounced level and registered single-cycle edge pulses.
// Ports:
//   clk_i    : system clock
//   rst_n_i  : asynchronous active-low reset
//   tick_i   : shared debounce tick, one clk cycle wide
//   raw_i    : raw pin level, asynchronous to clk_i
//   db_o     : debounced level
//   rise_o   : 1-cycle pulse on db_o 0->1
//   fall_o   : 1-cycle pulse on db_o 1->0
`timescale 1ns/1ps
module debounce_channel #(
  parameter int STABLE_TICKS = 10
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Any cycle of agreement clears progress, so a single-cycle glitch back to
  // the current level restarts qualification from zero.
  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        db_d   = sync2_q;
        rise_d = sync2_q;
        fall_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Input conditioning for raw board switches/buttons: synchronises each input
// into the clk_10mhz domain and debounces it against a shared prescaled tick.
// Ports:
//   clk_10mhz : 10 MHz system clock
//   rst_n     : asynchronous active-low reset
//   in_raw    : raw pin levels (asynchronous, may bounce)
//   in_db     : debounced level per channel
//   in_rise   : 1-cycle pulse per channel on in_db 0->1
//   in_fall   : 1-cycle pulse per channel on in_db 1->0
`timescale 1ns/1ps
module switch_debouncer
  import simple_fpga_cvs_pkg::*;
#(
  parameter int N_INPUTS     = 5,
  parameter int TICK_DIV     = DEBOUNCE_TICK_DIV_DEFAULT,
  parameter int STABLE_TICKS = 10
) (
  input  logic                clk_10mhz,
  input  logic                rst_n,
  input  logic [N_INPUTS-1:0] in_raw,
  output logic [N_INPUTS-1:0] in_db,
  output logic [N_INPUTS-1:0] in_rise,
  output logic [N_INPUTS-1:0] in_fall
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  // Explicit wrap at TICK_DIV-1 so non-power-of-two dividers keep the period.
  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  always_ff @(posedge clk_10mhz or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_chan
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clk_i   (clk_10mhz),
      .rst_n_i (rst_n),
      .tick_i  (tick),
      .raw_i   (in_raw[gi]),
      .db_o    (in_db[gi]),
      .rise_o  (in_rise[gi]),
      .fall_o  (in_fall[gi])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
`timescale 1ns/1ps
module tb_switch_debouncer;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in_raw;
  logic [N-1:0] in_db;
  logic [N-1:0] in_rise;
  logic [N-1:0] in_fall;

  int checks = 0;
  int errors = 0;

  int rise_cnt [N] = '{default: 0};
  int fall_cnt [N] = '{default: 0};
  int both_cnt = 0;

  always #50 clk = ~clk;

  switch_debouncer #(
    .N_INPUTS    (N),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk_10mhz (clk),
    .rst_n     (rst_n),
    .in_raw    (in_raw),
    .in_db     (in_db),
    .in_rise   (in_rise),
    .in_fall   (in_fall)
  );

  // Pulse tally: at posedge the outputs still show the cycle just ending.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (in_rise[i]) rise_cnt[i]++;
      if (in_fall[i]) fall_cnt[i]++;
      if (in_rise[i] && in_fall[i]) both_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic exp_tick;
    rst_n  = 1'b0;
    in_raw = '0;
    repeat (3) cyc();
    checks++;
    if ({in_db, in_rise, in_fall} !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {in_db, in_rise, in_fall});
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      cyc();
      exp_tick = ((i % 4) == 3);
      checks++;
      if ({in_db, in_rise, in_fall} !== 15'h0) begin
        errors++;
        $display("FAIL idle_outputs cycle %0d: got %h want 0", i, {in_db, in_rise, in_fall});
      end
      checks++;
      if (dut.tick !== exp_tick) begin
        errors++;
        $display("FAIL tick_phase cycle %0d: got %b want %b", i, dut.tick, exp_tick);
      end
    end
  endtask

  task automatic test_clean_edge();
    int seen = 0;
    int r0;
    r0 = rise_cnt[0];
    in_raw[0] = 1'b1;
    for (int n = 1; n <= 16 && seen == 0; n++) begin
      cyc();
      if (in_db[0] === 1'b1) begin
        seen = n;
        checks++;
        if (in_rise[0] !== 1'b1) begin
          errors++;
          $display("FAIL clean_rise_pulse: got %b want 1", in_rise[0]);
        end
      end
    end
    checks++;
    if (seen < 11 || seen > 14) begin
      errors++;
      $display("FAIL clean_latency: got %0d cycles want 11..14", seen);
    end
    cyc();
    checks++;
    if (in_rise[0] !== 1'b0 || in_db[0] !== 1'b1) begin
      errors++;
      $display("FAIL clean_after: got rise=%b db=%b want rise=0 db=1", in_rise[0], in_db[0]);
    end
    cyc();
    checks++;
    if (rise_cnt[0] - r0 != 1) begin
      errors++;
      $display("FAIL clean_rise_count: got %0d want 1", rise_cnt[0] - r0);
    end
    checks++;
    if (in_db[4:1] !== 4'b0000 || in_fall !== '0) begin
      errors++;
      $display("FAIL clean_others: got db=%b fall=%b want db[4:1]=0000 fall=0", in_db, in_fall);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pattern;
    int seen = 0;
    int r1;
    pattern = 4'b0101;
    r1 = rise_cnt[1];
    for (int p = 0; p < 4; p++) begin
      in_raw[1] = pattern[p];
      for (int k = 0; k < 5; k++) begin
        cyc();
        checks++;
        if (in_db[1] !== 1'b0 || in_rise[1] !== 1'b0) begin
          errors++;
          $display("FAIL bounce_hold: got db=%b rise=%b want 0 0", in_db[1], in_rise[1]);
        end
      end
    end
    in_raw[1] = 1'b1;
    for (int n = 1; n <= 16 && seen == 0; n++) begin
      cyc();
      if (in_db[1] === 1'b1) seen = n;
    end
    checks++;
    if (seen < 11 || seen > 14) begin
      errors++;
      $display("FAIL bounce_latency: got %0d cycles want 11..14", seen);
    end
    repeat (3) cyc();
    checks++;
    if (rise_cnt[1] - r1 != 1) begin
      errors++;
      $display("FAIL bounce_rise_count: got %0d want 1", rise_cnt[1] - r1);
    end
  endtask

  task automatic test_glitch();
    int r2;
    int f2;
    r2 = rise_cnt[2];
    f2 = fall_cnt[2];
    in_raw[2] = 1'b1;
    cyc();
    in_raw[2] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      checks++;
      if (in_db[2] !== 1'b0) begin
        errors++;
        $display("FAIL glitch_db cycle %0d: got %b want 0", k, in_db[2]);
      end
    end
    checks++;
    if (rise_cnt[2] != r2 || fall_cnt[2] != f2) begin
      errors++;
      $display("FAIL glitch_pulses: got rise=%0d fall=%0d want 0 0", rise_cnt[2] - r2, fall_cnt[2] - f2);
    end
  endtask

  task automatic test_falling_simultaneous();
    int seen = 0;
    int f3;
    int f4;
    in_raw[4:3] = 2'b11;
    repeat (20) cyc();
    checks++;
    if (in_db[4:3] !== 2'b11) begin
      errors++;
      $display("FAIL fall_setup: got %b want 11", in_db[4:3]);
    end
    f3 = fall_cnt[3];
    f4 = fall_cnt[4];
    in_raw[4:3] = 2'b00;
    for (int n = 1; n <= 16 && seen == 0; n++) begin
      cyc();
      if (in_db[3] === 1'b0 || in_db[4] === 1'b0) begin
        seen = n;
        checks++;
        if (in_db[4:3] !== 2'b00 || in_fall[4:3] !== 2'b11 || in_rise[4:3] !== 2'b00) begin
          errors++;
          $display("FAIL fall_together: got db=%b fall=%b rise=%b want 00 11 00",
                   in_db[4:3], in_fall[4:3], in_rise[4:3]);
        end
      end
    end
    checks++;
    if (seen < 11 || seen > 14) begin
      errors++;
      $display("FAIL fall_latency: got %0d cycles want 11..14", seen);
    end
    cyc();
    checks++;
    if (in_fall !== '0) begin
      errors++;
      $display("FAIL fall_width: got %b want 00000", in_fall);
    end
    cyc();
    checks++;
    if (fall_cnt[3] - f3 != 1 || fall_cnt[4] - f4 != 1 || both_cnt != 0) begin
      errors++;
      $display("FAIL fall_counts: got f3=%0d f4=%0d both=%0d want 1 1 0",
               fall_cnt[3] - f3, fall_cnt[4] - f4, both_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int seen0 = 0;
    int seen3 = 0;
    in_raw[3] = 1'b1;
    repeat (6) cyc();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_db, in_rise, in_fall} !== 15'h0) begin
      errors++;
      $display("FAIL midrst_immediate: got %h want 0", {in_db, in_rise, in_fall});
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if ({in_db, in_rise, in_fall} !== 15'h0) begin
        errors++;
        $display("FAIL midrst_hold cycle %0d: got %h want 0", k, {in_db, in_rise, in_fall});
      end
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      cyc();
      if (seen0 == 0 && in_db[0] === 1'b1) seen0 = n;
      if (seen3 == 0 && in_db[3] === 1'b1) seen3 = n;
    end
    checks++;
    if (seen3 != 12) begin
      errors++;
      $display("FAIL midrst_ch3_latency: got %0d want 12", seen3);
    end
    checks++;
    if (seen0 != 12) begin
      errors++;
      $display("FAIL midrst_ch0_latency: got %0d want 12", seen0);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    in_raw = '0;
    test_reset();
    test_clean_edge();
    test_bounce();
    test_glitch();
    test_falling_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
